// File: rtl/proc_ctrl_if.sv
// Control bundle between the instruction controller and the core datapath.
// The master (controller) drives the enables and handshakes; the slave (datapath) drives the opcode and status inputs.
interface proc_ctrl_if;
    logic [7:0] opcode;
    logic       fproc_ready;
    logic       sync_enable;
    logic       cstrobe_in;
    logic [2:0] alu_opcode;
    logic       alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic       c_strobe_enable;
    logic       reg_write_en;
    logic       instr_ptr_en;
    logic [1:0] instr_ptr_load_en;
    logic       qclk_load_en;
    logic       fproc_out_ready;
    logic       sync_out_ready;
    logic       done;
    logic       err_timeout;
    logic       err_illegal;

    modport master (
        input  opcode, fproc_ready, sync_enable, cstrobe_in,
        output alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en,
               instr_ptr_en, instr_ptr_load_en, qclk_load_en, fproc_out_ready,
               sync_out_ready, done, err_timeout, err_illegal
    );

    modport slave (
        output opcode, fproc_ready, sync_enable, cstrobe_in,
        input  alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en,
               instr_ptr_en, instr_ptr_load_en, qclk_load_en, fproc_out_ready,
               sync_out_ready, done, err_timeout, err_illegal
    );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle instruction control FSM for one processor core: decodes opcode[7:4] and sequences
// ALU, register write, instruction pointer, qclk, fproc and sync barrier operations.
module proc_ctrl_fsm #(
    parameter int FPROC_TIMEOUT = 0,
    parameter int SYNC_TIMEOUT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    proc_ctrl_if.master bus,
    output logic [2:0]  dbg_state
);
    // Handshakes: fproc_out_ready is a one-cycle request; the controller then waits for
    // fproc_ready (valid) to complete. sync_out_ready is held while parked at the barrier and
    // the cycle sync_enable is seen high completes the barrier. Both waits may time out.
    typedef enum logic [2:0] {
        S_DECODE, S_ALU_PROC, S_JUMP_COND, S_INC_QCLK,
        S_AF_WAIT, S_JF_WAIT, S_SYNC_WAIT, S_HALT
    } state_t;

    localparam logic [1:0] IN1_REG   = 2'd0;
    localparam logic [1:0] IN1_QCLK  = 2'd1;
    localparam logic [1:0] IN1_FPROC = 2'd2;

    localparam int MAXT = (FPROC_TIMEOUT > SYNC_TIMEOUT) ? FPROC_TIMEOUT : SYNC_TIMEOUT;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] F_LAST = CW'((FPROC_TIMEOUT > 0) ? FPROC_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] S_LAST = CW'((SYNC_TIMEOUT > 0) ? SYNC_TIMEOUT - 1 : 0);

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic          from_fproc;
    logic          fproc_to, sync_to;

    assign bus.alu_opcode  = bus.opcode[2:0];
    assign bus.alu_in0_sel = bus.opcode[3];
    assign dbg_state       = state;

    always_comb begin
        next_state            = state;
        bus.alu_in1_sel       = IN1_REG;
        bus.c_strobe_enable   = 1'b0;
        bus.reg_write_en      = 1'b0;
        bus.instr_ptr_en      = 1'b0;
        bus.instr_ptr_load_en = 2'd0;
        bus.qclk_load_en      = 1'b0;
        bus.fproc_out_ready   = 1'b0;
        bus.sync_out_ready    = 1'b0;
        bus.done              = 1'b0;
        bus.err_timeout       = 1'b0;
        bus.err_illegal       = 1'b0;
        fproc_to = (FPROC_TIMEOUT > 0) && (wait_cnt == F_LAST);
        sync_to  = (SYNC_TIMEOUT > 0) && (wait_cnt == S_LAST);

        case (state)
            S_DECODE: begin
                case (bus.opcode[7:4])
                    4'h0: begin
                        bus.c_strobe_enable = 1'b1;
                        bus.instr_ptr_en    = bus.cstrobe_in;
                    end
                    4'h1: next_state = S_ALU_PROC;
                    4'h2: begin
                        bus.instr_ptr_en      = 1'b1;
                        bus.instr_ptr_load_en = 2'd1;
                    end
                    4'h3: next_state = S_JUMP_COND;
                    4'h4: begin
                        bus.alu_in1_sel = IN1_QCLK;
                        next_state      = S_INC_QCLK;
                    end
                    4'h5: begin
                        bus.fproc_out_ready = 1'b1;
                        next_state          = S_AF_WAIT;
                    end
                    4'h6: begin
                        bus.fproc_out_ready = 1'b1;
                        next_state          = S_JF_WAIT;
                    end
                    4'h7: begin
                        bus.sync_out_ready = 1'b1;
                        next_state         = S_SYNC_WAIT;
                    end
                    4'h8: next_state = S_HALT;
                    // Undefined classes are flagged and skipped like a NOP.
                    default: begin
                        bus.err_illegal  = 1'b1;
                        bus.instr_ptr_en = 1'b1;
                    end
                endcase
            end
            S_ALU_PROC: begin
                bus.alu_in1_sel  = from_fproc ? IN1_FPROC : IN1_REG;
                bus.reg_write_en = 1'b1;
                bus.instr_ptr_en = 1'b1;
                next_state       = S_DECODE;
            end
            S_INC_QCLK: begin
                bus.alu_in1_sel  = IN1_QCLK;
                bus.qclk_load_en = 1'b1;
                bus.instr_ptr_en = 1'b1;
                next_state       = S_DECODE;
            end
            S_JUMP_COND: begin
                bus.alu_in1_sel       = from_fproc ? IN1_FPROC : IN1_REG;
                bus.instr_ptr_en      = 1'b1;
                bus.instr_ptr_load_en = 2'd2;
                next_state            = S_DECODE;
            end
            S_AF_WAIT, S_JF_WAIT: begin
                bus.alu_in1_sel = IN1_FPROC;
                if (bus.fproc_ready) begin
                    next_state = (state == S_AF_WAIT) ? S_ALU_PROC : S_JUMP_COND;
                end else if (fproc_to) begin
                    bus.err_timeout  = 1'b1;
                    bus.instr_ptr_en = 1'b1;
                    next_state       = S_DECODE;
                end
            end
            S_SYNC_WAIT: begin
                bus.sync_out_ready = 1'b1;
                if (bus.sync_enable) begin
                    bus.instr_ptr_en = 1'b1;
                    next_state       = S_DECODE;
                end else if (sync_to) begin
                    bus.err_timeout  = 1'b1;
                    bus.instr_ptr_en = 1'b1;
                    next_state       = S_DECODE;
                end
            end
            S_HALT: bus.done = 1'b1;
            default: next_state = S_DECODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_DECODE;
            wait_cnt   <= '0;
            from_fproc <= 1'b0;
        end else begin
            state      <= next_state;
            // Remembers whether ALU_PROC/JUMP_COND was reached through an fproc wait.
            from_fproc <= (state == S_AF_WAIT) || (state == S_JF_WAIT);
            if ((state == S_AF_WAIT || state == S_JF_WAIT || state == S_SYNC_WAIT) &&
                next_state == state) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: one task per instruction class / scenario, expected output
// vectors written by hand.
module tb_proc_ctrl_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    proc_ctrl_if b ();
    proc_ctrl_if b2 ();
    logic [2:0] st1, st2;

    assign b2.opcode      = b.opcode;
    assign b2.fproc_ready = b.fproc_ready;
    assign b2.sync_enable = b.sync_enable;
    assign b2.cstrobe_in  = b.cstrobe_in;

    proc_ctrl_fsm #(.FPROC_TIMEOUT(4), .SYNC_TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .bus(b), .dbg_state(st1));
    proc_ctrl_fsm #(.FPROC_TIMEOUT(0), .SYNC_TIMEOUT(3)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .dbg_state(st2));

    // Packed view: {in1[1:0], cse, rwe, ipe, ipl[1:0], qclk, fpo, syo, done, eto, eil}
    logic [12:0] o1, o2;
    assign o1 = {b.alu_in1_sel, b.c_strobe_enable, b.reg_write_en, b.instr_ptr_en,
                 b.instr_ptr_load_en, b.qclk_load_en, b.fproc_out_ready, b.sync_out_ready,
                 b.done, b.err_timeout, b.err_illegal};
    assign o2 = {b2.alu_in1_sel, b2.c_strobe_enable, b2.reg_write_en, b2.instr_ptr_en,
                 b2.instr_ptr_load_en, b2.qclk_load_en, b2.fproc_out_ready, b2.sync_out_ready,
                 b2.done, b2.err_timeout, b2.err_illegal};

    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] IN1Q = 13'h0800;
    localparam logic [12:0] IN1F = 13'h1000;
    localparam logic [12:0] CSE  = 13'h0400;
    localparam logic [12:0] RWE  = 13'h0200;
    localparam logic [12:0] IPE  = 13'h0100;
    localparam logic [12:0] IPL2 = 13'h0080;
    localparam logic [12:0] IPL1 = 13'h0040;
    localparam logic [12:0] QCL  = 13'h0020;
    localparam logic [12:0] FPO  = 13'h0010;
    localparam logic [12:0] SYO  = 13'h0008;
    localparam logic [12:0] DON  = 13'h0004;
    localparam logic [12:0] ETO  = 13'h0002;
    localparam logic [12:0] EIL  = 13'h0001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b.opcode = 8'h1D;
        b.fproc_ready = 1'b0;
        b.sync_enable = 1'b0;
        b.cstrobe_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (o1 !== NONE) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", o1, NONE);
        end
        checks++;
        if (st1 !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", st1);
        end
        checks++;
        if (b.alu_opcode !== 3'd5 || b.alu_in0_sel !== 1'b1) begin
            failures++;
            $display("FAIL alu_fields got=%0d/%0d exp=5/1", b.alu_opcode, b.alu_in0_sel);
        end
        b.opcode = 8'h20;
        tick();
    endtask

    task automatic test_reg_alu();
        b.opcode = 8'h10;
        #1;
        checks++;
        if (o1 !== NONE) begin
            failures++;
            $display("FAIL reg_alu_c1 got=%h exp=%h", o1, NONE);
        end
        tick();
        checks++;
        if (o1 !== (RWE | IPE)) begin
            failures++;
            $display("FAIL reg_alu_c2 got=%h exp=%h", o1, RWE | IPE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        b.opcode = 8'h20;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (o1 !== (IPE | IPL1)) begin
                failures++;
                $display("FAIL jump_i_%0d got=%h exp=%h", i, o1, IPE | IPL1);
            end
            tick();
        end
    endtask

    task automatic test_pulse();
        b.opcode = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b.cstrobe_in = (i == 5);
            #1;
            checks++;
            if (o1 !== ((i == 5) ? (CSE | IPE) : CSE)) begin
                failures++;
                $display("FAIL pulse_c%0d got=%h exp=%h", i, o1, (i == 5) ? (CSE | IPE) : CSE);
            end
            tick();
        end
        b.cstrobe_in = 1'b0;
    endtask

    task automatic test_jump_fproc();
        b.opcode = 8'h62;
        #1;
        checks++;
        if (o1 !== FPO) begin
            failures++;
            $display("FAIL jf_request got=%h exp=%h", o1, FPO);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            b.fproc_ready = (i == 2);
            #1;
            checks++;
            if (o1 !== IN1F) begin
                failures++;
                $display("FAIL jf_wait%0d got=%h exp=%h", i, o1, IN1F);
            end
            tick();
        end
        b.fproc_ready = 1'b0;
        #1;
        checks++;
        if (o1 !== (IN1F | IPE | IPL2)) begin
            failures++;
            $display("FAIL jf_jump got=%h exp=%h", o1, IN1F | IPE | IPL2);
        end
        tick();
    endtask

    task automatic test_jump_cond_reg();
        b.opcode = 8'h30;
        #1;
        checks++;
        if (o1 !== NONE) begin
            failures++;
            $display("FAIL jc_decode got=%h exp=%h", o1, NONE);
        end
        tick();
        checks++;
        if (o1 !== (IPE | IPL2)) begin
            failures++;
            $display("FAIL jc_jump got=%h exp=%h", o1, IPE | IPL2);
        end
        tick();
    endtask

    task automatic test_inc_qclk();
        b.opcode = 8'h40;
        #1;
        checks++;
        if (o1 !== IN1Q) begin
            failures++;
            $display("FAIL qclk_decode got=%h exp=%h", o1, IN1Q);
        end
        tick();
        checks++;
        if (o1 !== (IN1Q | QCL | IPE)) begin
            failures++;
            $display("FAIL qclk_load got=%h exp=%h", o1, IN1Q | QCL | IPE);
        end
        tick();
    endtask

    task automatic test_fproc_timeout();
        b.opcode = 8'h50;
        b.fproc_ready = 1'b0;
        #1;
        checks++;
        if (o1 !== FPO) begin
            failures++;
            $display("FAIL to_request got=%h exp=%h", o1, FPO);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o1 !== ((i == 3) ? (IN1F | ETO | IPE) : IN1F)) begin
                failures++;
                $display("FAIL to_wait%0d got=%h exp=%h", i, o1,
                         (i == 3) ? (IN1F | ETO | IPE) : IN1F);
            end
            tick();
        end
        b.opcode = 8'h20;
        #1;
        checks++;
        if (o1 !== (IPE | IPL1)) begin
            failures++;
            $display("FAIL to_back_decode got=%h exp=%h", o1, IPE | IPL1);
        end
        tick();
    endtask

    task automatic test_release_wins();
        b.opcode = 8'h50;
        tick();
        for (int i = 0; i < 4; i++) begin
            b.fproc_ready = (i == 3);
            #1;
            checks++;
            if (o1 !== IN1F) begin
                failures++;
                $display("FAIL rw_wait%0d got=%h exp=%h", i, o1, IN1F);
            end
            tick();
        end
        b.fproc_ready = 1'b0;
        #1;
        checks++;
        if (o1 !== (IN1F | RWE | IPE)) begin
            failures++;
            $display("FAIL rw_alu got=%h exp=%h", o1, IN1F | RWE | IPE);
        end
        tick();
    endtask

    task automatic test_sync();
        b.opcode = 8'h70;
        for (int i = 0; i <= 6; i++) begin
            b.sync_enable = (i == 6);
            #1;
            checks++;
            if (o1 !== ((i == 6) ? (SYO | IPE) : SYO)) begin
                failures++;
                $display("FAIL sync_c%0d got=%h exp=%h", i, o1, (i == 6) ? (SYO | IPE) : SYO);
            end
            tick();
        end
        b.sync_enable = 1'b0;
        b.opcode = 8'h20;
        #1;
        checks++;
        if (o1 !== (IPE | IPL1)) begin
            failures++;
            $display("FAIL sync_back_decode got=%h exp=%h", o1, IPE | IPL1);
        end
        tick();
    endtask

    task automatic test_done_reset();
        b.opcode = 8'h80;
        #1;
        checks++;
        if (o1 !== NONE) begin
            failures++;
            $display("FAIL done_decode got=%h exp=%h", o1, NONE);
        end
        tick();
        b.opcode = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o1 !== DON) begin
                failures++;
                $display("FAIL halt_c%0d got=%h exp=%h", i, o1, DON);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (o1 !== (EIL | IPE)) begin
                failures++;
                $display("FAIL illegal_c%0d got=%h exp=%h", i, o1, EIL | IPE);
            end
            tick();
        end
    endtask

    task automatic test_sync_timeout();
        reset = 1'b1;
        b.opcode = 8'h20;
        b.sync_enable = 1'b0;
        tick();
        reset = 1'b0;
        b.opcode = 8'h70;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o2 !== ((i == 3) ? (SYO | ETO | IPE) : SYO)) begin
                failures++;
                $display("FAIL sync_to_c%0d got=%h exp=%h", i, o2,
                         (i == 3) ? (SYO | ETO | IPE) : SYO);
            end
            tick();
        end
        b.opcode = 8'h20;
        #1;
        checks++;
        if (st2 !== 3'd0) begin
            failures++;
            $display("FAIL sync_to_state got=%0d exp=0", st2);
        end
    endtask

    initial begin
        test_reset();
        test_reg_alu();
        test_back_to_back();
        test_pulse();
        test_jump_fproc();
        test_jump_cond_reg();
        test_inc_qclk();
        test_fproc_timeout();
        test_release_wins();
        test_sync();
        test_done_reset();
        test_sync_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
